stream_switch_splitter_regs: RTL and testbench

STREAM_SWITCH_SPLITTER_REGS -- requirements
Module: stream_switch_splitter_regs

---
 rtl/stream_switch_pkg.sv | 39 +++
 rtl/stream_switch_splitter_regs.sv | 188 ++++++++++++++++++
 tb/tb_stream_switch_splitter_regs.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_switch_pkg.sv
// Shared definitions for the stream switch splitter register block:
// register offsets, the default ID value, AXI-Lite response codes,
// FSM state types and the address decoder used by read and write paths.
package stream_switch_pkg;

    localparam logic [31:0] C_ID_DEFAULT = 32'h5353_0001;

    localparam logic [11:0] OFF_ID      = 12'h000;
    localparam logic [11:0] OFF_CTRL    = 12'h004;
    localparam logic [11:0] OFF_SCRATCH = 12'h008;
    localparam logic [11:0] OFF_PKT_CNT = 12'h00C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    typedef enum logic [1:0] {REG_ID, REG_CTRL, REG_SCRATCH, REG_PKT_CNT} reg_e;

    typedef struct packed {
        logic hit;
        reg_e sel;
    } dec_t;

    // Decodes a word index (address bits [11:2]) to a register select.
    function automatic dec_t decode(input logic [9:0] widx);
        dec_t d;
        d.hit = 1'b1;
        d.sel = REG_ID;
        if (widx == OFF_ID[11:2])           d.sel = REG_ID;
        else if (widx == OFF_CTRL[11:2])    d.sel = REG_CTRL;
        else if (widx == OFF_SCRATCH[11:2]) d.sel = REG_SCRATCH;
        else if (widx == OFF_PKT_CNT[11:2]) d.sel = REG_PKT_CNT;
        else                                d.hit = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/stream_switch_splitter_regs.sv
// AXI-Lite control/status register block for the stream switch splitter.
// Registers: ID (RO), CTRL (RW [2:0]), SCRATCH (RW), PKT_CNT (count of
// pkt_inc pulses; any write clears it).
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axil_aw*/w*/b*      AXI-Lite write address, data and response channels
//   s_axil_ar*/r*         AXI-Lite read address and data channels
//   pkt_inc               one-cycle pulse per packet split
//   ctrl_enable           CTRL[0]
//   ctrl_select           CTRL[2:1]
module stream_switch_splitter_regs
    import stream_switch_pkg::*;
#(
    parameter logic [31:0] C_ID = C_ID_DEFAULT
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_axil_awvalid,
    input  logic [31:0] s_axil_awaddr,
    output logic        s_axil_awready,
    input  logic        s_axil_wvalid,
    input  logic [31:0] s_axil_wdata,
    output logic        s_axil_wready,
    output logic        s_axil_bvalid,
    output logic [1:0]  s_axil_bresp,
    input  logic        s_axil_bready,
    input  logic        s_axil_arvalid,
    input  logic [31:0] s_axil_araddr,
    output logic        s_axil_arready,
    output logic        s_axil_rvalid,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    input  logic        s_axil_rready,
    input  logic        pkt_inc,
    output logic        ctrl_enable,
    output logic [1:0]  ctrl_select
);

    wstate_e     wstate_q, wstate_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [9:0]  awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  bresp_q, bresp_d;

    rstate_e     rstate_q, rstate_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    logic        aw_hs, w_hs, ar_hs;
    logic [9:0]  wr_widx;
    logic [31:0] wr_data;
    dec_t        wr_dec, rd_dec;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                                s_axil_araddr[31:12], s_axil_araddr[1:0]};

    assign s_axil_awready = (wstate_q == W_IDLE) && !aw_got_q && !areset;
    assign s_axil_wready  = (wstate_q == W_IDLE) && !w_got_q && !areset;
    assign s_axil_arready = (rstate_q == R_IDLE) && !areset;
    assign s_axil_bvalid  = (wstate_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = (rstate_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ctrl_enable    = ctrl_q[0];
    assign ctrl_select    = ctrl_q[2:1];

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    // A channel captured in an earlier cycle takes precedence over the bus.
    assign wr_widx = aw_got_q ? awaddr_q : s_axil_awaddr[11:2];
    assign wr_data = w_got_q ? wdata_q : s_axil_wdata;
    assign wr_dec  = decode(wr_widx);
    assign rd_dec  = decode(s_axil_araddr[11:2]);

    // Write channel FSM plus register updates on commit.
    always_comb begin
        wstate_d  = wstate_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        pkt_cnt_d = pkt_inc ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
        case (wstate_q)
            W_IDLE: begin
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    wstate_d = W_RESP;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (wr_dec.hit && wr_dec.sel != REG_ID) begin
                        bresp_d = RESP_OKAY;
                        case (wr_dec.sel)
                            REG_CTRL:    ctrl_d    = wr_data[2:0];
                            REG_SCRATCH: scratch_d = wr_data;
                            // Clear wins over the count, but a same-edge pulse still counts.
                            REG_PKT_CNT: pkt_cnt_d = {31'd0, pkt_inc};
                            default:     ;
                        endcase
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end else begin
                    if (aw_hs) begin
                        aw_got_d = 1'b1;
                        awaddr_d = s_axil_awaddr[11:2];
                    end
                    if (w_hs) begin
                        w_got_d = 1'b1;
                        wdata_d = s_axil_wdata;
                    end
                end
            end
            W_RESP: if (s_axil_bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read mux samples pre-edge register values, so a same-edge write is not seen.
    always_comb begin
        rd_val = '0;
        case (rd_dec.sel)
            REG_ID:      rd_val = C_ID;
            REG_CTRL:    rd_val = {29'd0, ctrl_q};
            REG_SCRATCH: rd_val = scratch_q;
            REG_PKT_CNT: rd_val = pkt_cnt_q;
            default:     rd_val = '0;
        endcase
        if (!rd_dec.hit) rd_val = '0;
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                rstate_d = R_DATA;
                rdata_d  = rd_val;
                rresp_d  = rd_dec.hit ? RESP_OKAY : RESP_SLVERR;
            end
            R_DATA: if (s_axil_rready) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            bresp_q   <= '0;
            rstate_q  <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ctrl_q    <= '0;
            scratch_q <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_switch_splitter_regs.sv
// Self-checking bench for stream_switch_splitter_regs: a vector table of
// register reads/writes plus hand-written sequences for channel ordering,
// response back-pressure, counter clear/wrap and reset abandonment.
// Expected responses are queued when a transaction is issued and compared
// by a monitor when the DUT completes the response handshake.
module tb_stream_switch_splitter_regs;

    localparam logic [31:0] EXP_ID = 32'h5353_0001;
    localparam logic [1:0]  OK     = 2'b00;
    localparam logic [1:0]  SERR   = 2'b10;

    logic        aclk, areset;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_wvalid, s_axil_wready;
    logic [31:0] s_axil_wdata;
    logic        s_axil_bvalid, s_axil_bready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_rvalid, s_axil_rready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        pkt_inc, ctrl_enable;
    logic [1:0]  ctrl_select;

    stream_switch_splitter_regs dut (
        .aclk(aclk), .areset(areset),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awready(s_axil_awready),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wdata(s_axil_wdata),
        .s_axil_wready(s_axil_wready),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bresp(s_axil_bresp),
        .s_axil_bready(s_axil_bready),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_araddr(s_axil_araddr),
        .s_axil_arready(s_axil_arready),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp), .s_axil_rready(s_axil_rready),
        .pkt_inc(pkt_inc), .ctrl_enable(ctrl_enable), .ctrl_select(ctrl_select)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    exp_t wq[$];
    exp_t rq[$];
    vec_t vecs[14];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s act=timeout exp=handshake", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard: compare each completed response with the oldest expectation.
    always @(negedge aclk) begin
        exp_t e;
        if (!areset) begin
            if (s_axil_bvalid && s_axil_bready) begin
                if (wq.size() == 0) timeout_fail("b_unexpected");
                else begin
                    e = wq.pop_front();
                    check("bresp", {30'd0, s_axil_bresp}, {30'd0, e.resp});
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (rq.size() == 0) timeout_fail("r_unexpected");
                else begin
                    e = rq.pop_front();
                    check("rresp", {30'd0, s_axil_rresp}, {30'd0, e.resp});
                    check("rdata", s_axil_rdata, e.data);
                end
            end
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        s_axil_awaddr = a; s_axil_wdata = d;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = s_axil_awvalid && s_axil_awready;
            w_hs  = s_axil_wvalid && s_axil_wready;
            tick();
            if (aw_hs) begin aw_done = 1; s_axil_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_axil_wvalid = 1'b0;  end
            n++;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        if (!(aw_done && w_done)) timeout_fail("wr_addr_data");
        n = 0;
        while (!s_axil_bvalid && n < 20) begin tick(); n++; end
        if (!s_axil_bvalid) timeout_fail("wr_resp");
        else begin s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0; end
    endtask

    task automatic axi_read(input logic [31:0] a);
        bit hs;
        int n;
        hs = 0; n = 0;
        s_axil_araddr = a; s_axil_arvalid = 1'b1;
        while (!hs && n < 20) begin
            hs = s_axil_arready;
            tick();
            n++;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) timeout_fail("rd_addr");
        n = 0;
        while (!s_axil_rvalid && n < 20) begin tick(); n++; end
        if (!s_axil_rvalid) timeout_fail("rd_data");
        else begin s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0; end
    endtask

    task automatic wr_exp(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        wq.push_back('{r, 32'h0});
        axi_write(a, d);
    endtask

    task automatic rd_exp(input logic [31:0] a, input logic [1:0] r, input logic [31:0] d);
        rq.push_back('{r, d});
        axi_read(a);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, OK,   32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         OK,   32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, OK,   32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         OK,   32'h0000_0007};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0,         SERR, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         OK,   EXP_ID};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         SERR, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, SERR, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_1008, 32'h0,         OK,   32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 32'h0000_000B, 32'h0,         OK,   32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0,         SERR, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0004, 32'h0000_0002, OK,   32'h0};
        vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         OK,   32'h0000_0002};
        vecs[13] = '{1'b0, 32'h0000_000C, 32'h0,         OK,   32'h0};

        areset = 1'b1; pkt_inc = 1'b0;
        s_axil_awvalid = 1'b0; s_axil_awaddr = '0; s_axil_wvalid = 1'b0; s_axil_wdata = '0;
        s_axil_bready = 1'b0; s_axil_arvalid = 1'b0; s_axil_araddr = '0; s_axil_rready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", {31'd0, s_axil_awready}, 32'd0);
        check("rst_wready",  {31'd0, s_axil_wready},  32'd0);
        check("rst_arready", {31'd0, s_axil_arready}, 32'd0);
        check("rst_bvalid",  {31'd0, s_axil_bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, s_axil_rvalid},  32'd0);
        areset = 1'b0;
        #1;
        check("post_rst_awready", {31'd0, s_axil_awready}, 32'd1);
        check("post_rst_wready",  {31'd0, s_axil_wready},  32'd1);
        check("post_rst_arready", {31'd0, s_axil_arready}, 32'd1);
        check("post_rst_ctrl", {29'd0, ctrl_select, ctrl_enable}, 32'd0);
        check("post_rst_rdata", s_axil_rdata, 32'd0);

        // ID read latency: rvalid in the cycle right after the AR handshake
        s_axil_araddr = 32'h0; s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        check("id_rvalid_latency", {31'd0, s_axil_rvalid}, 32'd1);
        rq.push_back('{OK, EXP_ID});
        s_axil_rready = 1'b1; tick(); s_axil_rready = 1'b0;

        // Vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) wr_exp(vecs[i].addr, vecs[i].data, vecs[i].resp);
            else            rd_exp(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
        end
        check("tbl_ctrl_outputs", {29'd0, ctrl_select, ctrl_enable}, 32'd2);

        // AW at cycle 0, W at cycle 3, bvalid at cycle 4
        s_axil_awaddr = 32'h4; s_axil_awvalid = 1'b1;
        tick();
        s_axil_awvalid = 1'b0;
        check("aw_first_awready", {31'd0, s_axil_awready}, 32'd0);
        check("aw_first_wready",  {31'd0, s_axil_wready},  32'd1);
        tick();
        tick();
        check("aw_first_no_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
        s_axil_wdata = 32'h5; s_axil_wvalid = 1'b1;
        tick();
        s_axil_wvalid = 1'b0;
        check("late_w_bvalid", {31'd0, s_axil_bvalid}, 32'd1);
        check("late_w_bresp", {30'd0, s_axil_bresp}, 32'd0);
        check("late_w_enable", {31'd0, ctrl_enable}, 32'd1);
        check("late_w_select", {30'd0, ctrl_select}, 32'd2);

        // B back-pressure: response held, next AW stalled until B handshake
        s_axil_awaddr = 32'h8; s_axil_awvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid",  {31'd0, s_axil_bvalid},  32'd1);
            check("bp_bresp",   {30'd0, s_axil_bresp},   32'd0);
            check("bp_awready", {31'd0, s_axil_awready}, 32'd0);
            check("bp_wready",  {31'd0, s_axil_wready},  32'd0);
            tick();
        end
        wq.push_back('{OK, 32'h0});
        s_axil_bready = 1'b1;
        tick();
        s_axil_bready = 1'b0;
        check("bp_awready_after_b", {31'd0, s_axil_awready}, 32'd1);
        s_axil_wdata = 32'h0000_1234; s_axil_wvalid = 1'b1;
        wq.push_back('{OK, 32'h0});
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        check("bp_next_bvalid", {31'd0, s_axil_bvalid}, 32'd1);
        s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
        rd_exp(32'h8, OK, 32'h0000_1234);

        // Same-edge read and write of SCRATCH: read returns the old value
        s_axil_awaddr = 32'h8; s_axil_wdata = 32'hCAFE_0000; s_axil_araddr = 32'h8;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_arvalid = 1'b1;
        wq.push_back('{OK, 32'h0});
        rq.push_back('{OK, 32'h0000_1234});
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
        s_axil_bready = 1'b1; s_axil_rready = 1'b1;
        tick();
        s_axil_bready = 1'b0; s_axil_rready = 1'b0;
        rd_exp(32'h8, OK, 32'hCAFE_0000);

        // PKT_CNT counting, clear coinciding with pkt_inc, wrap
        pkt_inc = 1'b1;
        repeat (7) tick();
        pkt_inc = 1'b0;
        rd_exp(32'hC, OK, 32'd7);
        s_axil_awaddr = 32'hC; s_axil_wdata = 32'h0;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; pkt_inc = 1'b1;
        wq.push_back('{OK, 32'h0});
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; pkt_inc = 1'b0;
        s_axil_bready = 1'b1; tick(); s_axil_bready = 1'b0;
        rd_exp(32'hC, OK, 32'd1);
        wr_exp(32'hC, 32'hFFFF_FFFF, OK);
        rd_exp(32'hC, OK, 32'd0);
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_cnt_q;
        rd_exp(32'hC, OK, 32'hFFFF_FFFF);
        pkt_inc = 1'b1; tick(); pkt_inc = 1'b0;
        rd_exp(32'hC, OK, 32'd0);

        // Reset while a read response is pending
        wr_exp(32'h4, 32'h1, OK);
        check("pre_rst_enable", {31'd0, ctrl_enable}, 32'd1);
        s_axil_araddr = 32'h8; s_axil_arvalid = 1'b1;
        tick();
        s_axil_arvalid = 1'b0;
        check("pre_rst_rvalid", {31'd0, s_axil_rvalid}, 32'd1);
        areset = 1'b1;
        tick();
        check("mid_rst_rvalid", {31'd0, s_axil_rvalid}, 32'd0);
        check("mid_rst_enable", {31'd0, ctrl_enable}, 32'd0);
        check("mid_rst_rdata", s_axil_rdata, 32'd0);
        areset = 1'b0;
        s_axil_rready = 1'b1;
        repeat (3) tick();
        s_axil_rready = 1'b0;
        check("abandoned_rvalid", {31'd0, s_axil_rvalid}, 32'd0);
        rd_exp(32'h8, OK, 32'h0);

        check("wq_drained", wq.size(), 32'd0);
        check("rq_drained", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
